// File: rtl/mio_bus_if.sv
// CPU <-> memory/IO request bus used by the SCPU memory interface.
// The master drives the request; the slave answers with ready and read data.
interface mio_bus_if;
  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] addr;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, addr, Data_out,
    input  Data_in, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, addr, Data_out,
    output Data_in, MIO_ready
  );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: decodes RAM, GPIO and optional cycle counter windows.
// Define MIO_COUNTER_EN to build the free-running counter at 0xF000_0000.
module mio_bus_responder #(
  parameter int          RAM_AW   = 10,
  parameter int          RAM_WAIT = 1,
  parameter logic [15:0] LED_RST  = 16'h0000
) (
  input  logic              clk,
  input  logic              rstn,
  mio_bus_if.slave          bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  localparam int         HI        = RAM_AW + 2;
  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);
  localparam logic [29:0] GPIO_W   = 30'h3800_0000;
  localparam logic [29:0] CNT_W    = 30'h3C00_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    R_RAM,
    R_GPIO,
    R_CNT,
    R_NONE
  } region_t;

  state_t      state;
  state_t      state_n;
  region_t     region_d;
  region_t     region_q;
  logic        rw_q;
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        acc_last;
  logic [31:0] rdata;
  logic        is_ram;
  logic        is_gpio;
  logic        is_cnt;
  logic        unused_lsb;

  assign unused_lsb = ^bus.addr[1:0];
  assign is_ram     = bus.addr[31:HI] == '0;
  assign is_gpio    = bus.addr[31:2] == GPIO_W;

`ifdef MIO_COUNTER_EN
  logic [31:0] cnt;
  logic [31:0] cnt_snap;

  assign is_cnt = bus.addr[31:2] == CNT_W;

  // Free-running cycle counter; a CPU write loads it instead of incrementing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      cnt_snap <= '0;
    end else begin
      if (acc_last && rw_q && region_q == R_CNT)
        cnt <= ram_din;
      else
        cnt <= cnt + 32'd1;
      if (state == S_ACCESS && region_q == R_CNT)
        cnt_snap <= cnt;
    end
  end
`else
  logic unused_cnt;

  assign is_cnt     = 1'b0;
  assign unused_cnt = ^CNT_W;
`endif

  // Address window decode of the incoming request.
  always_comb begin
    region_d = R_NONE;
    unique case (1'b1)
      is_ram:  region_d = R_RAM;
      is_gpio: region_d = R_GPIO;
      is_cnt:  region_d = R_CNT;
      default: region_d = R_NONE;
    endcase
  end

  // Read data mux; writes and unmapped accesses return zero.
  always_comb begin
    rdata = '0;
    if (!rw_q) begin
      unique case (region_q)
        R_RAM:   rdata = ram_dout;
        R_GPIO:  rdata = {16'h0000, sw_in};
`ifdef MIO_COUNTER_EN
        R_CNT:   rdata = cnt_snap;
`endif
        default: rdata = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next state plus accept / end-of-access strobes.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    acc_last = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.CPU_MIO) begin
          accept  = 1'b1;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (region_q != R_RAM || wait_cnt == '0) begin
          acc_last = 1'b1;
          state_n  = S_RESP;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Request latch, RAM strobe, wait count, LED register and response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      rw_q        <= 1'b0;
      region_q    <= R_NONE;
      wait_cnt    <= '0;
      led_out     <= LED_RST;
      bus.Data_in   <= '0;
      bus.MIO_ready <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (accept) begin
        ram_addr <= bus.addr[HI-1:2];
        ram_din  <= bus.Data_out;
        rw_q     <= bus.MemRW;
        region_q <= region_d;
        wait_cnt <= (region_d == R_RAM) ? WAIT_INIT : '0;
        ram_we   <= bus.MemRW && region_d == R_RAM;
      end
      if (state == S_ACCESS && wait_cnt != '0)
        wait_cnt <= wait_cnt - 4'd1;
      if (acc_last && rw_q && region_q == R_GPIO)
        led_out <= ram_din[15:0];
      bus.MIO_ready <= state == S_RESP;
      if (state == S_RESP)
        bus.Data_in <= rdata;
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder (RAM_WAIT=1 and RAM_WAIT=3 copies).
// Build with +define+MIO_COUNTER_EN to exercise the counter window.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  ra1, ra3;
  logic        we1, we3;
  logic [31:0] din1, din3;
  logic [31:0] dout1, dout3;
  logic [15:0] sw1, sw3;
  logic [15:0] led1, led3;
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  mio_bus_if bus1 ();
  mio_bus_if bus3 ();

  always #5 clk = ~clk;

  mio_bus_responder #(.RAM_AW(10), .RAM_WAIT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .ram_addr(ra1), .ram_we(we1), .ram_din(din1),
    .ram_dout(dout1), .sw_in(sw1), .led_out(led1)
  );

  mio_bus_responder #(.RAM_AW(10), .RAM_WAIT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .bus(bus3),
    .ram_addr(ra3), .ram_we(we3), .ram_din(din3),
    .ram_dout(dout3), .sw_in(sw3), .led_out(led3)
  );

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (we1) mem1[ra1] <= din1;
    dout1 <= mem1[ra1];
    if (we3) mem3[ra3] <= din3;
    dout3 <= mem3[ra3];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic m, input logic rw,
                       input logic [31:0] a, input logic [31:0] d);
    if (w == 1) begin
      bus1.CPU_MIO = m; bus1.MemRW = rw;
      bus1.addr = a;    bus1.Data_out = d;
    end else begin
      bus3.CPU_MIO = m; bus3.MemRW = rw;
      bus3.addr = a;    bus3.Data_out = d;
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 1) ? bus1.MIO_ready : bus3.MIO_ready;
  endfunction

  // One request, strobe held for the accept edge only; inputs are then
  // scrambled so only the latched copies can produce the right answer.
  task automatic txn(input int w, input logic rw, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output int lat, output int wes, output logic [9:0] ra);
    bit done;
    done = 0;
    lat  = 0;
    @(negedge clk);
    drive(w, 1'b1, rw, a, d);
    @(posedge clk); #1;
    wes = (w == 1) ? int'(we1) : int'(we3);
    ra  = (w == 1) ? ra1 : ra3;
    drive(w, 1'b0, ~rw, ~a, ~d);
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      if (((w == 1) ? we1 : we3) === 1'b1) wes++;
      if (rdy(w) === 1'b1) begin
        lat  = k;
        done = 1;
      end
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    rd = (w == 1) ? bus1.Data_in : bus3.Data_in;
    @(posedge clk); #1;
    check("ready_pulse", {31'd0, rdy(w)}, 32'd0);
  endtask

  logic [31:0] rd;
  int          lat, wes;
  logic [9:0]  ra;

  initial begin
    rstn = 1'b0;
    sw1 = 16'h0000; sw3 = 16'h0000;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus1.MIO_ready}, 32'd0);
    check("rst_data", bus1.Data_in, 32'h0);
    check("rst_we", {31'd0, we1}, 32'd0);
    check("rst_addr", {22'd0, ra1}, 32'd0);
    check("rst_led", {16'd0, led1}, 32'h0);
    @(negedge clk) rstn = 1'b1;

    txn(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat, wes, ra);
    check("w_ram_lat", 32'(lat), 32'd2);
    check("w_ram_we", 32'(wes), 32'd1);
    check("w_ram_addr", {22'd0, ra}, 32'd4);
    check("w_ram_data", rd, 32'h0);

    txn(1, 1'b0, 32'h0000_0010, 32'h0, rd, lat, wes, ra);
    check("r_ram_data", rd, 32'hDEAD_BEEF);
    check("r_ram_lat", 32'(lat), 32'd2);
    check("r_ram_we", 32'(wes), 32'd0);

    txn(3, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, rd, lat, wes, ra);
    check("w3_lat", 32'(lat), 32'd4);
    check("w3_we", 32'(wes), 32'd1);
    txn(3, 1'b0, 32'h0000_0010, 32'h0, rd, lat, wes, ra);
    check("r3_lat", 32'(lat), 32'd4);
    check("r3_data", rd, 32'h0BAD_F00D);

    txn(1, 1'b1, 32'h0000_0FFC, 32'h0000_55AA, rd, lat, wes, ra);
    check("w_top_addr", {22'd0, ra}, 32'h3FF);
    txn(1, 1'b0, 32'h0000_0FFC, 32'h0, rd, lat, wes, ra);
    check("r_top_data", rd, 32'h0000_55AA);

    sw1 = 16'h00FF;
    txn(1, 1'b1, 32'hE000_0000, 32'h1234_A5A5, rd, lat, wes, ra);
    check("w_gpio_lat", 32'(lat), 32'd2);
    check("w_gpio_led", {16'd0, led1}, 32'h0000_A5A5);
    check("w_gpio_we", 32'(wes), 32'd0);
    txn(1, 1'b0, 32'hE000_0000, 32'h0, rd, lat, wes, ra);
    check("r_gpio_data", rd, 32'h0000_00FF);
    check("r_gpio_lat", 32'(lat), 32'd2);
    sw1 = 16'h8001;
    txn(1, 1'b0, 32'hE000_0003, 32'h0, rd, lat, wes, ra);
    check("r_gpio_lsb", rd, 32'h0000_8001);

    txn(1, 1'b0, 32'h8000_0000, 32'h0, rd, lat, wes, ra);
    check("r_unmap_data", rd, 32'h0);
    check("r_unmap_lat", 32'(lat), 32'd2);
    txn(1, 1'b1, 32'h8000_0000, 32'hFFFF_0000, rd, lat, wes, ra);
    check("w_unmap_led", {16'd0, led1}, 32'h0000_A5A5);
    check("w_unmap_we", 32'(wes), 32'd0);
    txn(1, 1'b0, 32'h0000_1000, 32'h0, rd, lat, wes, ra);
    check("r_past_ram", rd, 32'h0);

    txn(1, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, rd, lat, wes, ra);
    check("w_cnt_lat", 32'(lat), 32'd2);
    txn(1, 1'b0, 32'hF000_0000, 32'h0, rd, lat, wes, ra);
`ifdef MIO_COUNTER_EN
    check("r_cnt_wrap", rd, 32'h0000_0001);
`else
    check("r_cnt_off", rd, 32'h0);
`endif

    txn(1, 1'b1, 32'h0000_0020, 32'h1111_1111, rd, lat, wes, ra);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_BABE);
    @(posedge clk); #1;
    check("abort_we_hi", {31'd0, we1}, 32'd1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("abort_we", {31'd0, we1}, 32'd0);
    check("abort_addr", {22'd0, ra1}, 32'd0);
    check("abort_led", {16'd0, led1}, 32'h0);
    check("abort_data", bus1.Data_in, 32'h0);
    check("abort_ready", {31'd0, bus1.MIO_ready}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    txn(1, 1'b0, 32'h0000_0020, 32'h0, rd, lat, wes, ra);
    check("after_rst_data", rd, 32'h1111_1111);
    check("after_rst_lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
